// File: rtl/bram_dp.sv
// bram_dp - parametrised simple-dual-port block RAM.
//
// One write port and one read port share a single clock. Writes are
// byte-lane masked. A same-address read/write collision returns either the
// old word (RDW_MODE=0) or the merged new word (RDW_MODE=1). An optional
// output register adds one cycle of read latency. An optional hardware
// clear sequence zeroes the whole array after every reset.
//
// The array itself has no reset term and a single masked write port, so
// Yosys can map it onto iCE40 EBR. The collision bypass and the output
// register are kept outside the array.
//
// Ports:
//   clk      in   system clock, all logic on the rising edge
//   rst_n    in   synchronous active-low reset
//   wr_en    in   write request
//   wr_addr  in   write address            [ADDR_WIDTH-1:0]
//   wr_data  in   write data               [DATA_WIDTH-1:0]
//   wr_be    in   byte enables, bit i gates wr_data[8i+7:8i]
//   rd_en    in   read request
//   rd_addr  in   read address             [ADDR_WIDTH-1:0]
//   rd_data  out  read data, held between reads
//   rd_valid out  one-cycle pulse marking new rd_data
//   ready    out  1 when the ports accept requests
module bram_dp #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter     INIT_FILE      = "",
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    ready
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [ADDR_WIDTH-1:0]   clr_addr_next;
    logic                    clearing;

    logic                    wr_fire;
    logic                    rd_fire;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NUM_LANES-1:0]    mem_wbe;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DATA_WIDTH-1:0]   rd_word_q;
    logic                    byp_hit_q;
    logic [DATA_WIDTH-1:0]   byp_data_q;
    logic [NUM_LANES-1:0]    byp_be_q;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    s1_valid;

    // State register for the clear sequencer. Reset always restarts the
    // sweep at address zero, even when it lands in the middle of a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // Next-state logic. CLEAR writes one word per cycle and leaves after
    // the last address, so the sweep lasts exactly DEPTH cycles.
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        clearing      = 1'b0;
        ready         = 1'b0;
        case (state)
            CLEAR: begin
                clearing      = 1'b1;
                clr_addr_next = clr_addr + ADDR_ONE;
                if (clr_addr == '1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Requests are only honoured while running and out of reset.
    assign wr_fire = rst_n && ready && wr_en;
    assign rd_fire = rst_n && ready && rd_en;

    // The clear sequencer and the user port share the single physical
    // write port; a clear is simply a full-width write of zero.
    assign mem_we    = rst_n && (clearing || wr_fire);
    assign mem_waddr = clearing ? clr_addr : wr_addr;
    assign mem_wdata = clearing ? '0 : wr_data;
    assign mem_wbe   = clearing ? '1 : wr_be;

    // Byte-masked write port of the array.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mem_wbe[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read port. The non-blocking read yields pre-write data on
    // a collision; the write side is captured alongside so the bypass can
    // rebuild the merged word without touching the array.
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            rd_word_q  <= mem[rd_addr];
            byp_hit_q  <= wr_fire && (wr_addr == rd_addr);
            byp_data_q <= wr_data;
            byp_be_q   <= wr_be;
        end
    end

    // Write-through bypass: overlay the enabled lanes of the colliding write.
    always_comb begin
        rd_word = rd_word_q;
        if ((RDW_MODE != 0) && byp_hit_q) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (byp_be_q[i]) begin
                    rd_word[8*i +: 8] = byp_data_q[8*i +: 8];
                end
            end
        end
    end

    // First-stage valid flag tracking the registered read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_fire;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_data_q;
            logic                  out_valid_q;

            // Output pipeline stage; only loads on a valid word so rd_data
            // holds between reads.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_data_q  <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= s1_valid;
                    if (s1_valid) begin
                        out_data_q <= rd_word;
                    end
                end
            end

            assign rd_data  = out_data_q;
            assign rd_valid = out_valid_q;
        end else begin : g_no_out_reg
            logic has_data_q;

            // The read register itself cannot be reset without breaking EBR
            // inference, so rd_data is forced to zero until the first read
            // after reset. The read register holds between reads.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    has_data_q <= 1'b0;
                end else if (rd_fire) begin
                    has_data_q <= 1'b1;
                end
            end

            assign rd_data  = has_data_q ? rd_word : '0;
            assign rd_valid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_bram_dp.sv
// tb_bram_dp - self-checking bench for bram_dp.
//
// Four instances with different RDW_MODE / OUT_REG / CLEAR_ON_RESET
// settings share one stimulus stream. A behavioural model (plain memory
// array plus a latency delay line per instance) predicts rd_data, rd_valid
// and ready; one process compares every instance against it on every
// falling edge. Directed literal checks pin the model to hand-worked values.
//
//   inst  RDW_MODE  OUT_REG  CLEAR_ON_RESET
//   0     0         0        0
//   1     1         1        0
//   2     1         0        0
//   3     0         1        1
module tb_bram_dp;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NBE  = DW / 8;
    localparam int NDUT = 4;
    localparam int DEPTH = 2 ** AW;

    localparam bit [NDUT-1:0] RDW_TAB  = 4'b0110;
    localparam bit [NDUT-1:0] OREG_TAB = 4'b1010;
    localparam bit [NDUT-1:0] CLR_TAB  = 4'b1000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [NBE-1:0] wr_be;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;

    logic [DW-1:0]  rd_data_v  [NDUT];
    logic           rd_valid_v [NDUT];
    logic           ready_v    [NDUT];

    // Model state.
    logic [DW-1:0]  model_mem [NDUT][DEPTH];
    int             busy      [NDUT];
    logic           last_v    [NDUT];
    logic [DW-1:0]  last_d    [NDUT];
    logic           prev_v    [NDUT];
    logic [DW-1:0]  prev_d    [NDUT];
    logic           exp_valid [NDUT];
    logic [DW-1:0]  exp_data  [NDUT];
    bit             model_on = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bram_dp #(
            .DATA_WIDTH     (DW),
            .ADDR_WIDTH     (AW),
            .INIT_FILE      (""),
            .RDW_MODE       (RDW_TAB[g]  ? 1 : 0),
            .OUT_REG        (OREG_TAB[g] ? 1 : 0),
            .CLEAR_ON_RESET (CLR_TAB[g]  ? 1 : 0)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .wr_be    (wr_be),
            .rd_en    (rd_en),
            .rd_addr  (rd_addr),
            .rd_data  (rd_data_v[g]),
            .rd_valid (rd_valid_v[g]),
            .ready    (ready_v[g])
        );
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Behavioural model: applied once per rising edge with the inputs the
    // DUT sampled at that edge.
    task automatic modelEdge();
        logic [DW-1:0] old_w;
        logic [DW-1:0] merged;
        for (int k = 0; k < NDUT; k++) begin
            if (!rst_n) begin
                busy[k]      = CLR_TAB[k] ? DEPTH : 0;
                last_v[k]    = 1'b0;
                prev_v[k]    = 1'b0;
                exp_valid[k] = 1'b0;
                exp_data[k]  = '0;
            end else begin
                prev_v[k] = last_v[k];
                prev_d[k] = last_d[k];
                last_v[k] = 1'b0;
                if (busy[k] != 0) begin
                    model_mem[k][DEPTH - busy[k]] = '0;
                    busy[k]--;
                end else begin
                    merged = model_mem[k][wr_addr];
                    for (int b = 0; b < NBE; b++) begin
                        if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
                    end
                    old_w = model_mem[k][rd_addr];
                    if (rd_en) begin
                        last_v[k] = 1'b1;
                        last_d[k] = (RDW_TAB[k] && wr_en && (wr_addr == rd_addr)) ? merged : old_w;
                    end
                    if (wr_en) model_mem[k][wr_addr] = merged;
                end
                exp_valid[k] = OREG_TAB[k] ? prev_v[k] : last_v[k];
                if (exp_valid[k]) exp_data[k] = OREG_TAB[k] ? prev_d[k] : last_d[k];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic [NBE-1:0] be,
                                 input logic re, input logic [AW-1:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = ra;
        tick();
    endtask

    task automatic countNotReady(output int n, output logic saw_valid);
        n         = 0;
        saw_valid = 1'b0;
        while (!ready_v[3] && n < 40) begin
            saw_valid = saw_valid | rd_valid_v[3];
            n++;
            tick();
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < NDUT; k++) begin
                checkOutput($sformatf("inst%0d rd_valid", k), {31'b0, rd_valid_v[k]}, {31'b0, exp_valid[k]});
                checkOutput($sformatf("inst%0d rd_data", k), rd_data_v[k], exp_data[k]);
                checkOutput($sformatf("inst%0d ready", k), {31'b0, ready_v[k]}, {31'b0, busy[k] == 0});
            end
        end
    end

    initial begin
        int   n;
        logic saw;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_be = '0; rd_en = 1'b0; rd_addr = '0;
        tick();
        model_on = 1'b1;

        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("reset inst%0d rd_data", k), rd_data_v[k], 32'h0);
            checkOutput($sformatf("reset inst%0d rd_valid", k), {31'b0, rd_valid_v[k]}, 32'h0);
        end
        checkOutput("reset inst0 ready", {31'b0, ready_v[0]}, 32'h1);
        checkOutput("reset inst3 ready", {31'b0, ready_v[3]}, 32'h0);

        rst_n = 1'b1;
        countNotReady(n, saw);
        checkOutput("initial clear length", DW'(n), 32'd16);

        // Fill every address with a known non-zero pattern.
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b1, AW'(a), DW'(32'h10203040 + a * 32'h01010101), 4'hF, 1'b0, '0);
        end

        // Basic write then read.
        applyStimulus(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd3);
        checkOutput("basic inst0 data", rd_data_v[0], 32'hDEADBEEF);
        checkOutput("basic inst0 valid", {31'b0, rd_valid_v[0]}, 32'h1);
        checkOutput("basic inst1 early valid", {31'b0, rd_valid_v[1]}, 32'h0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        checkOutput("basic inst1 data", rd_data_v[1], 32'hDEADBEEF);
        checkOutput("basic inst1 valid", {31'b0, rd_valid_v[1]}, 32'h1);
        checkOutput("hold inst0 data", rd_data_v[0], 32'hDEADBEEF);
        checkOutput("hold inst0 valid", {31'b0, rd_valid_v[0]}, 32'h0);

        // Byte enables, plus an all-lanes-off write colliding with the read.
        applyStimulus(1'b1, 4'd5, 32'h11223344, 4'hF, 1'b0, '0);
        applyStimulus(1'b1, 4'd5, 32'hAABBCCDD, 4'b0101, 1'b0, '0);
        applyStimulus(1'b1, 4'd5, 32'hFFFFFFFF, 4'b0000, 1'b1, 4'd5);
        checkOutput("byte_en inst0", rd_data_v[0], 32'h11BB33DD);
        checkOutput("byte_en inst2", rd_data_v[2], 32'h11BB33DD);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        checkOutput("byte_en inst3", rd_data_v[3], 32'h11BB33DD);

        // Same-address collision.
        applyStimulus(1'b1, 4'd7, 32'h00000001, 4'hF, 1'b0, '0);
        applyStimulus(1'b1, 4'd7, 32'h000000FF, 4'h1, 1'b1, 4'd7);
        checkOutput("collide inst0 read-old", rd_data_v[0], 32'h00000001);
        checkOutput("collide inst2 write-through", rd_data_v[2], 32'h000000FF);
        applyStimulus(1'b1, 4'd8, 32'hCAFEF00D, 4'hF, 1'b1, 4'd7);
        checkOutput("collide inst1 write-through", rd_data_v[1], 32'h000000FF);
        checkOutput("collide inst3 read-old", rd_data_v[3], 32'h00000001);
        checkOutput("other-addr inst2", rd_data_v[2], 32'h000000FF);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);

        // Pipelined back-to-back reads on the registered-output instance.
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd0);
        checkOutput("pipe step0 valid", {31'b0, rd_valid_v[1]}, 32'h0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd1);
        checkOutput("pipe step1 data", rd_data_v[1], 32'h10203040);
        checkOutput("pipe step1 valid", {31'b0, rd_valid_v[1]}, 32'h1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd2);
        checkOutput("pipe step2 data", rd_data_v[1], 32'h11213141);
        checkOutput("pipe step2 valid", {31'b0, rd_valid_v[1]}, 32'h1);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        checkOutput("pipe step3 data", rd_data_v[1], 32'h12223242);
        checkOutput("pipe step3 valid", {31'b0, rd_valid_v[1]}, 32'h1);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        checkOutput("pipe step4 valid", {31'b0, rd_valid_v[1]}, 32'h0);

        // Clear after a one-cycle reset, with reads requested during it.
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        rst_n = 1'b1;
        rd_en = 1'b1;
        rd_addr = 4'd2;
        countNotReady(n, saw);
        checkOutput("clear length", DW'(n), 32'd16);
        checkOutput("clear no rd_valid", {31'b0, saw}, 32'h0);
        for (int a = 0; a <= DEPTH; a++) begin
            applyStimulus(1'b0, '0, '0, '0, a < DEPTH, AW'(a));
            if (a >= 1) begin
                checkOutput($sformatf("cleared addr %0d valid", a - 1), {31'b0, rd_valid_v[3]}, 32'h1);
                checkOutput($sformatf("cleared addr %0d data", a - 1), rd_data_v[3], 32'h0);
            end
        end

        // Reset landing in the middle of a clear.
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        rst_n = 1'b1;
        repeat (7) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd1);
        checkOutput("pre-reset inst0 data", rd_data_v[0], 32'h11213141);
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("midclear inst%0d rd_data", k), rd_data_v[k], 32'h0);
            checkOutput($sformatf("midclear inst%0d rd_valid", k), {31'b0, rd_valid_v[k]}, 32'h0);
        end
        rst_n = 1'b1;
        countNotReady(n, saw);
        checkOutput("midclear length", DW'(n), 32'd16);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd9);
        repeat (3) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
